sram_req_sequencer: RTL and testbench
=====================================

Name: sram_req_sequencer

Overview:
- Front-end stage directly upstream of the icoboard_sram controller; drives its local bus (address, write_data, write_enable, lower_byte, upper_byte) and consumes read_data.
- Accepts word read/write commands over a valid/ready interface and issues at most one SRAM access per pclk.
- Inserts a bus turnaround cycle between a write and a following read.
- Returns read data, tagged with its address, a fixed number of cycles after issue.

Parameters:
- ADDR_W, 19, word-address width (512K x 16 SRAM).
- DATA_W, 16, data width.
- READ_LATENCY, 2, pclk cycles from read issue on the local bus to valid read_data; legal range 1..4.
- TURNAROUND, 1, idle cycles inserted on a write->read transition; legal values 0 or 1.

Ports:
- pclk  in  1  global clock.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  word address.
- cmd_be  in  2  byte enables: bit0 = lower byte, bit1 = upper byte.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid for one cycle; no backpressure.
- rsp_addr  out  ADDR_W  address of the returned read.
- rsp_data  out  DATA_W  read data.
- address  out  ADDR_W  to SRAM controller.
- write_data  out  DATA_W  to SRAM controller.
- write_enable  out  1  to SRAM controller.
- lower_byte  out  1  to SRAM controller.
- upper_byte  out  1  to SRAM controller.
- read_data  in  DATA_W  from SRAM controller.

Behaviour:
- Clock/reset: one clock, pclk. Reset resetn is asynchronous, active-low.
- Reset values:
  - address = 0, write_data = 0.
  - write_enable = 0, lower_byte = 0, upper_byte = 0.
  - rsp_valid = 0, rsp_addr = 0, rsp_data = 0.
  - Latency pipe cleared; last_was_write = 0.
- Bus outputs are registered.
- Accepted command (cycle N): at edge N+1, bus outputs are loaded as follows:
  - address = cmd_addr.
  - write_enable = cmd_write.
  - lower_byte = cmd_be[0], upper_byte = cmd_be[1].
  - write_data = cmd_wdata for writes; write_data holds its previous value on reads.
- No accepted command: at the next edge, write_enable, lower_byte and upper_byte = 0. address and write_data hold (idle bus).
- cmd_ready is combinational:
  - TURNAROUND=1: cmd_ready = !(last_was_write && cmd_valid && !cmd_write).
  - TURNAROUND=0: cmd_ready = 1.
  - last_was_write is set in the cycle a write is issued on the bus and cleared by any non-write bus cycle.
  - A stalled read is accepted the next cycle, so a write->read pair costs exactly one idle bus cycle.
- Commands with cmd_be = 0 are accepted and issued as a no-op bus cycle (enables low). A read with cmd_be = 0 still produces a response whose rsp_data is unspecified.
- Read return:
  - A READ_LATENCY-deep shift pipe carries {valid, addr} from each read issue.
  - When the pipe tail is valid, rsp_valid = 1 one cycle after read_data is sampled, i.e. READ_LATENCY+1 cycles after the bus issue edge.
  - rsp_data and rsp_addr hold until the next response.
- Responses return in issue order; back-to-back reads give back-to-back rsp_valid.
- Address wrap: addresses are unsigned ADDR_W; no arithmetic is performed, so any address including all-ones is legal.
- Reset asserted mid-operation: in-flight reads are dropped and no rsp_valid is produced for them. The bus goes idle asynchronously.
- Simultaneous read response and new command: independent paths; both proceed in the same cycle.

Optional Feature:
- Macro SRAM_REQ_STATS_EN.
- Defined: adds outputs stat_reads and stat_writes (32 bit each). Each counts accepted commands of its type, with cmd_be = 0 counted too. Counters wrap at 2^32 and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, idle stimulus (cmd_valid = 0) -> all bus outputs and rsp_valid stay 0; address = 0 for 10 cycles.
- Write A=0x00010, D=0xBEEF, be=3, then read A=0x00010 (READ_LATENCY=2, TURNAROUND=1), with a behavioural SRAM model:
  - cmd_ready drops for exactly 1 cycle on the read.
  - rsp_valid asserts 3 cycles after the read issue, with rsp_addr = 0x00010 and rsp_data = 0xBEEF.
- 8 back-to-back reads at 0x7FFF8..0x7FFFF -> 8 consecutive rsp_valid pulses with matching rsp_addr in order, and no stall.
- Write with be=2 data 0x1234 over an existing 0xABCD, then read -> 0x12CD; the lower_byte = 0 and upper_byte = 1 strobes are checked on the bus.
- Issue 2 reads, assert resetn low 1 cycle after the second issue -> no rsp_valid after reset; outputs return to reset values immediately.
- SRAM_REQ_STATS_EN defined, 5 writes + 3 reads -> stat_writes = 5, stat_reads = 3.

Source files
------------

// File: rtl/sram_req_sequencer.sv
// Command sequencer in front of the icoboard SRAM controller: one bus access per pclk,
// write->read turnaround, fixed-latency tagged read return. Optional counters: SRAM_REQ_STATS_EN.
module sram_req_sequencer #(
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned TURNAROUND   = 1
) (
    input  logic              pclk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_be,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    output logic              lower_byte,
    output logic              upper_byte,
    input  logic [DATA_W-1:0] read_data
`ifdef SRAM_REQ_STATS_EN
    ,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes
`endif
);

    localparam int unsigned TAIL = READ_LATENCY - 1;

    logic              cmd_accept;

    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              write_enable_q, write_enable_d;
    logic              lower_byte_q, lower_byte_d;
    logic              upper_byte_q, upper_byte_d;
    logic              last_was_write_q, last_was_write_d;
    logic              rd_issue_q, rd_issue_d;

    logic              pipe_vld_q  [READ_LATENCY];
    logic              pipe_vld_d  [READ_LATENCY];
    logic [ADDR_W-1:0] pipe_addr_q [READ_LATENCY];
    logic [ADDR_W-1:0] pipe_addr_d [READ_LATENCY];

    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

`ifdef SRAM_REQ_STATS_EN
    logic [31:0]       stat_reads_q, stat_reads_d;
    logic [31:0]       stat_writes_q, stat_writes_d;
`endif

    // A read directly behind a bus write is held off for one cycle
    always_comb begin
        cmd_ready = 1'b1;
        if (TURNAROUND != 0 && last_was_write_q && cmd_valid && !cmd_write) begin
            cmd_ready = 1'b0;
        end
    end

    always_comb begin
        cmd_accept       = cmd_valid && cmd_ready;

        address_d        = address_q;
        write_data_d     = write_data_q;
        write_enable_d   = 1'b0;
        lower_byte_d     = 1'b0;
        upper_byte_d     = 1'b0;
        last_was_write_d = 1'b0;
        rd_issue_d       = 1'b0;
        rsp_valid_d      = 1'b0;
        rsp_addr_d       = rsp_addr_q;
        rsp_data_d       = rsp_data_q;

        if (cmd_accept) begin
            address_d        = cmd_addr;
            write_enable_d   = cmd_write;
            lower_byte_d     = cmd_be[0];
            upper_byte_d     = cmd_be[1];
            last_was_write_d = cmd_write;
            rd_issue_d       = !cmd_write;
            if (cmd_write) begin
                write_data_d = cmd_wdata;
            end
        end

        // Pipe stage 0 tags the read currently on the bus; the tail lines up with read_data
        pipe_vld_d[0]  = rd_issue_q;
        pipe_addr_d[0] = address_q;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end

        if (pipe_vld_q[TAIL]) begin
            rsp_valid_d = 1'b1;
            rsp_addr_d  = pipe_addr_q[TAIL];
            rsp_data_d  = read_data;
        end
    end

`ifdef SRAM_REQ_STATS_EN
    always_comb begin
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
        if (cmd_accept) begin
            if (cmd_write) begin
                stat_writes_d = stat_writes_q + 32'd1;
            end else begin
                stat_reads_d  = stat_reads_q + 32'd1;
            end
        end
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`endif

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            address_q        <= '0;
            write_data_q     <= '0;
            write_enable_q   <= 1'b0;
            lower_byte_q     <= 1'b0;
            upper_byte_q     <= 1'b0;
            last_was_write_q <= 1'b0;
            rd_issue_q       <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_addr_q       <= '0;
            rsp_data_q       <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_addr_q[i] <= '0;
            end
        end else begin
            address_q        <= address_d;
            write_data_q     <= write_data_d;
            write_enable_q   <= write_enable_d;
            lower_byte_q     <= lower_byte_d;
            upper_byte_q     <= upper_byte_d;
            last_was_write_q <= last_was_write_d;
            rd_issue_q       <= rd_issue_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_addr_q       <= rsp_addr_d;
            rsp_data_q       <= rsp_data_d;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_d[i];
                pipe_addr_q[i] <= pipe_addr_d[i];
            end
        end
    end

    assign address      = address_q;
    assign write_data   = write_data_q;
    assign write_enable = write_enable_q;
    assign lower_byte   = lower_byte_q;
    assign upper_byte   = upper_byte_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_addr     = rsp_addr_q;
    assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_sram_req_sequencer.sv
// Scoreboard bench for sram_req_sequencer: SRAM device model, reference memory,
// directed scenarios then randomized traffic.
module tb_sram_req_sequencer;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RL     = 2;
    localparam int unsigned TA     = 1;

    logic              pclk = 1'b0;
    logic              resetn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [1:0]        cmd_be = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              write_enable;
    logic              lower_byte;
    logic              upper_byte;
    logic [DATA_W-1:0] read_data = '0;
`ifdef SRAM_REQ_STATS_EN
    logic [31:0]       stat_reads;
    logic [31:0]       stat_writes;
    int unsigned       exp_reads = 0;
    int unsigned       exp_writes = 0;
`endif

    always #5 pclk = ~pclk;

    sram_req_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .TURNAROUND(TA)
    ) dut (
        .pclk(pclk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .address(address), .write_data(write_data), .write_enable(write_enable),
        .lower_byte(lower_byte), .upper_byte(upper_byte), .read_data(read_data)
`ifdef SRAM_REQ_STATS_EN
        , .stat_reads(stat_reads), .stat_writes(stat_writes)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int          cyc = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    // SRAM device model: sees the registered bus, returns data RL edges after issue
    logic [DATA_W-1:0] sram [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] dly [4];

    always @(posedge pclk) begin : sram_model
        logic [DATA_W-1:0] cur;
        logic [DATA_W-1:0] w;
        cur = '0;
        w = sram.exists(address) ? sram[address] : init_word(address);
        if (write_enable) begin
            if (lower_byte) w[7:0]  = write_data[7:0];
            if (upper_byte) w[15:8] = write_data[15:8];
            if (lower_byte || upper_byte) sram[address] = w;
        end else begin
            cur = w;
        end
        for (int i = 3; i > 0; i--) dly[i] = dly[i-1];
        dly[0] = cur;
        read_data <= dly[RL-1];
    end

    // Reference: in-order word memory, expected response per accepted read
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                chk_data;
        int                due;
    } exp_t;

    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    exp_t              sb [$];

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    always @(negedge pclk) begin : monitor
        exp_t e;
        if (resetn) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_spurious", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_time", 64'(cyc), 64'(e.due));
                    check("rsp_addr", 64'(rsp_addr), 64'(e.addr));
                    if (e.chk_data) check("rsp_data", 64'(rsp_data), 64'(e.data));
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("rsp_missing", 64'(rsp_valid), 64'd1);
            end
        end
    end

    // Expected bus state and turnaround state
    logic [ADDR_W-1:0] x_addr = '0;
    logic [DATA_W-1:0] x_wdata = '0;
    logic              x_we = 1'b0, x_lb = 1'b0, x_ub = 1'b0;
    bit                last_wr = 1'b0;

    task automatic step(input bit v, input bit w, input logic [ADDR_W-1:0] a,
                        input logic [1:0] be, input logic [DATA_W-1:0] d, output bit acc);
        logic [DATA_W-1:0] m;
        bit                x_rdy;
        cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_be = be; cmd_wdata = d;
        @(negedge pclk);
        check("bus", {25'd0, address, write_data, write_enable, lower_byte, upper_byte},
                     {25'd0, x_addr, x_wdata, x_we, x_lb, x_ub});
        x_rdy = (TA == 0) || !(last_wr && v && !w);
        check("cmd_ready", 64'(cmd_ready), 64'(x_rdy));
        acc = v && cmd_ready;
        last_wr = acc && w;
        if (acc) begin
            x_addr = a; x_we = w; x_lb = be[0]; x_ub = be[1];
            if (w) begin
                x_wdata = d;
                m = ref_read(a);
                if (be[0]) m[7:0]  = d[7:0];
                if (be[1]) m[15:8] = d[15:8];
                if (be != 2'b00) ref_mem[a] = m;
            end else begin
                sb.push_back('{addr: a, data: ref_read(a), chk_data: (be != 2'b00), due: cyc + int'(RL) + 2});
            end
`ifdef SRAM_REQ_STATS_EN
            if (w) exp_writes++; else exp_reads++;
`endif
        end else begin
            x_we = 1'b0; x_lb = 1'b0; x_ub = 1'b0;
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic send(input bit w, input logic [ADDR_W-1:0] a, input logic [1:0] be,
                        input logic [DATA_W-1:0] d, output int stalls);
        bit acc;
        stalls = 0;
        do begin
            step(1'b1, w, a, be, d, acc);
            if (!acc) stalls++;
        end while (!acc && stalls < 8);
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1'b0, 1'b0, '0, 2'b00, '0, acc);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int               st;
        int               tot;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] ahi;
        repeat (3) @(posedge pclk);
        #1 resetn = 1'b1;
        check("reset_rsp", {rsp_valid, rsp_addr, rsp_data}, 64'd0);

        // Idle after reset: bus must stay quiet at address 0
        idle(10);

        // Write then read the same word: one stall, data returns
        send(1'b1, 19'h00010, 2'b11, 16'hBEEF, st);
        check("write_stall", 64'(st), 64'd0);
        send(1'b0, 19'h00010, 2'b11, 16'h0000, st);
        check("turnaround_stall", 64'(st), 64'(TA));
        idle(RL + 3);

        // Eight back-to-back reads at the top of the address space
        tot = 0;
        ahi = 19'h7FFF8;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, ahi + ADDR_W'(i), 2'b11, 16'h0000, st);
            tot += st;
        end
        check("b2b_no_stall", 64'(tot), 64'd0);
        idle(RL + 3);

        // Upper-byte-only write merges into an existing word
        send(1'b1, 19'h00200, 2'b11, 16'hABCD, st);
        send(1'b1, 19'h00200, 2'b10, 16'h1234, st);
        send(1'b0, 19'h00200, 2'b11, 16'h0000, st);
        check("merge_ref", 64'(ref_read(19'h00200)), 64'h12CD);
        idle(RL + 3);

        // Reset with two reads in flight: nothing may come back
        send(1'b0, 19'h00300, 2'b11, 16'h0000, st);
        send(1'b0, 19'h00301, 2'b11, 16'h0000, st);
        idle(1);
        resetn = 1'b0;
        #1;
        check("rst_bus", {25'd0, address, write_data, write_enable, lower_byte, upper_byte}, 64'd0);
        check("rst_rsp", {rsp_valid, rsp_addr, rsp_data}, 64'd0);
        sb.delete();
        x_addr = '0; x_wdata = '0; x_we = 1'b0; x_lb = 1'b0; x_ub = 1'b0; last_wr = 1'b0;
`ifdef SRAM_REQ_STATS_EN
        exp_reads = 0; exp_writes = 0;
`endif
        cmd_valid = 1'b0;
        repeat (2) @(posedge pclk);
        #1 resetn = 1'b1;
        idle(RL + 6);

        // Randomized traffic over a small colliding address set
        for (int i = 0; i < 300; i++) begin
            a = ADDR_W'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) a = a | 19'h7FFF0;
            if ($urandom_range(0, 3) == 0) idle(1);
            send(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 16'($urandom), st);
        end
        idle(RL + 4);
        check("sb_drained", 64'(sb.size()), 64'd0);
`ifdef SRAM_REQ_STATS_EN
        check("stat_reads", 64'(stat_reads), 64'(exp_reads));
        check("stat_writes", 64'(stat_writes), 64'(exp_writes));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
